// File: rtl/four_banks_byte_writer_if.sv
// ---------------------------------------------------------------------------
// four_banks_byte_writer_if
// Byte-stream input and four-bank masked write bus of the byte writer.
//   in_valid/in_ready/in_data/bank_sel/byte_sel/in_last/flush : byte source side
//   wr_we/wr_data/wr_be/wr_ack                                : bank side
// Modports:
//   slave  : the byte writer itself
//   master : the environment (byte source plus the four banks)
// ---------------------------------------------------------------------------
interface four_banks_byte_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  bank_sel;
  logic [1:0]  byte_sel;
  logic        in_last;
  logic        flush;
  logic [3:0]  wr_we;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [3:0]  wr_ack;

  modport slave (
    input  in_valid, in_data, bank_sel, byte_sel, in_last, flush, wr_ack,
    output in_ready, wr_we, wr_data, wr_be
  );

  modport master (
    output in_valid, in_data, bank_sel, byte_sel, in_last, flush, wr_ack,
    input  in_ready, wr_we, wr_data, wr_be
  );
endinterface

// File: rtl/four_banks_byte_writer.sv
// ---------------------------------------------------------------------------
// four_banks_byte_writer
// Packs a tagged byte stream into a 32-bit staging word with byte enables and
// issues one masked write to one of four banks, held until that bank acks or
// the write times out.
// Ports:
//   wb_clk_i : clock
//   rst_n    : asynchronous active-low reset
//   bus      : byte stream in, masked bank write out (slave modport)
//   busy     : FSM not idle
//   err      : sticky write-timeout flag
//   err_clr  : clears err (a timeout in the same cycle keeps it set)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | staging word empty, waiting for the first byte
// FILL  | staging word partly filled, merging bytes for the same bank
// WRITE | strobe asserted to stage bank, waiting for ack or timeout
// ---------------------------------------------------------------------------
module four_banks_byte_writer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_n,
  four_banks_byte_writer_if.slave  bus,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clr
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

  state_t           state_q,      state_d;
  logic [1:0]       stage_bank_q, stage_bank_d;
  logic [31:0]      stage_data_q, stage_data_d;
  logic [3:0]       stage_be_q,   stage_be_d;
  logic             pend_v_q,     pend_v_d;
  logic [7:0]       pend_data_q,  pend_data_d;
  logic [1:0]       pend_bank_q,  pend_bank_d;
  logic [1:0]       pend_lane_q,  pend_lane_d;
  logic             pend_last_q,  pend_last_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             err_q,        err_d;
  logic [3:0]       wr_we_q,      wr_we_d;
  logic [31:0]      wr_data_q,    wr_data_d;
  logic [3:0]       wr_be_q,      wr_be_d;

  logic        accept;
  logic        word_done;
  logic        ack_hit;
  logic        expired;
  logic [31:0] in_word;
  logic [3:0]  in_be;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign bus.in_ready = (state_q != WRITE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign in_be        = 4'b0001 << bus.byte_sel;
  assign in_word      = {24'd0, bus.in_data} << {bus.byte_sel, 3'b000};
  assign word_done    = bus.in_last | (bus.byte_sel == 2'd3);
  assign ack_hit      = bus.wr_ack[stage_bank_q];
  assign expired      = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    stage_bank_d = stage_bank_q;
    stage_data_d = stage_data_q;
    stage_be_d   = stage_be_q;
    pend_v_d     = pend_v_q;
    pend_data_d  = pend_data_q;
    pend_bank_d  = pend_bank_q;
    pend_lane_d  = pend_lane_q;
    pend_last_d  = pend_last_q;
    cnt_d        = cnt_q;
    err_d        = err_q & ~err_clr;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stage_bank_d = bus.bank_sel;
          stage_data_d = in_word;
          stage_be_d   = in_be;
          state_d      = word_done ? WRITE : FILL;
        end
      end

      FILL: begin
        if (accept && (bus.bank_sel == stage_bank_q)) begin
          stage_data_d = (stage_data_q & ~be_to_mask(in_be)) | in_word;
          stage_be_d   = stage_be_q | in_be;
          if (word_done || bus.flush) state_d = WRITE;
        end else if (accept) begin
          // Byte for another bank: park it and flush the current word first.
          pend_v_d    = 1'b1;
          pend_data_d = bus.in_data;
          pend_bank_d = bus.bank_sel;
          pend_lane_d = bus.byte_sel;
          pend_last_d = bus.in_last;
          state_d     = WRITE;
        end else if (bus.flush) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        if (ack_hit || expired) begin
          // An ack arriving in the expiry cycle still counts as success.
          if (!ack_hit) err_d = 1'b1;
          cnt_d = '0;
          if (pend_v_q) begin
            pend_v_d     = 1'b0;
            stage_bank_d = pend_bank_q;
            stage_data_d = {24'd0, pend_data_q} << {pend_lane_q, 3'b000};
            stage_be_d   = 4'b0001 << pend_lane_q;
            state_d      = (pend_last_q || (pend_lane_q == 2'd3)) ? WRITE : FILL;
          end else begin
            stage_data_d = '0;
            stage_be_d   = '0;
            state_d      = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so the strobe rises the cycle
    // after the completing byte and falls the cycle after the ack.
    if (state_d == WRITE) begin
      wr_we_d   = 4'b0001 << stage_bank_d;
      wr_data_d = stage_data_d & be_to_mask(stage_be_d);
      wr_be_d   = stage_be_d;
    end else begin
      wr_we_d   = '0;
      wr_data_d = '0;
      wr_be_d   = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stage_bank_q <= '0;
      stage_data_q <= '0;
      stage_be_q   <= '0;
      pend_v_q     <= 1'b0;
      pend_data_q  <= '0;
      pend_bank_q  <= '0;
      pend_lane_q  <= '0;
      pend_last_q  <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wr_we_q      <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
    end else begin
      state_q      <= state_d;
      stage_bank_q <= stage_bank_d;
      stage_data_q <= stage_data_d;
      stage_be_q   <= stage_be_d;
      pend_v_q     <= pend_v_d;
      pend_data_q  <= pend_data_d;
      pend_bank_q  <= pend_bank_d;
      pend_lane_q  <= pend_lane_d;
      pend_last_q  <= pend_last_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      wr_we_q      <= wr_we_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
    end
  end

  assign bus.wr_we   = wr_we_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_be   = wr_be_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_four_banks_byte_writer.sv
// ---------------------------------------------------------------------------
// tb_four_banks_byte_writer
// Directed table of single-word writes, hand-written multi-cycle corner cases
// (bank switch with parked byte, timeout, wrong-bank ack, reset mid-write) and
// a randomized phase checked against a transaction-level packing model.
// ---------------------------------------------------------------------------
module tb_four_banks_byte_writer;
  localparam int TIMEOUT = 16;

  logic wb_clk_i = 1'b0;
  logic rst_n;
  logic busy, err, err_clr;

  four_banks_byte_writer_if bus();

  four_banks_byte_writer #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
  endtask

  task automatic drive_byte(input bit v, input logic [1:0] bank, input logic [1:0] lane,
                            input logic [7:0] d, input bit last, input bit fl);
    bus.in_valid = v;
    bus.bank_sel = bank;
    bus.byte_sel = lane;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.flush    = fl;
  endtask

  task automatic idle_in();
    drive_byte(1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- directed single-word table ----------------
  typedef struct {
    int          n;
    logic [1:0]  bank;
    logic [7:0]  lanes;     // lane of byte i at [2i+1:2i]
    logic [31:0] bytes;     // byte i at [8i+7:8i]
    bit          last;      // in_last on the final byte
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[4];

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [1:0]  bank;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  bit          open;
  logic [1:0]  ob;
  logic [31:0] od;
  logic [3:0]  obe;
  bit          err_exp;

  bit          in_txn;
  logic [3:0]  t_we;
  logic [31:0] t_data;
  logic [3:0]  t_be;
  int          held;
  int          ack_delay;

  task automatic emit();
    wr_t w;
    w.bank = ob; w.data = od; w.be = obe;
    exp_q.push_back(w);
    open = 1'b0; od = '0; obe = '0;
  endtask

  task automatic open_word(input logic [1:0] bank, input logic [1:0] lane, input logic [7:0] d);
    open = 1'b1; ob = bank; od = '0; obe = '0;
    od[8*lane +: 8] = d;
    obe[lane] = 1'b1;
  endtask

  task automatic model_step(input bit ir, input bit v, input logic [1:0] bank,
                            input logic [1:0] lane, input logic [7:0] d,
                            input bit last, input bit fl);
    if (!ir) return;
    if (v) begin
      if (!open) begin
        open_word(bank, lane, d);
        if (last || lane == 2'd3) emit();
      end else if (bank == ob) begin
        od[8*lane +: 8] = d;
        obe[lane] = 1'b1;
        if (last || lane == 2'd3 || fl) emit();
      end else begin
        emit();
        open_word(bank, lane, d);
        if (last || lane == 2'd3) emit();
      end
    end else if (fl && open) begin
      emit();
    end
  endtask

  task automatic rand_cycle(input bit allow_in, input bit force_flush);
    logic [3:0] ack;
    bit         to;
    bit         clr;
    bit         v, last, fl, ir;
    logic [1:0] b, l;
    logic [7:0] d;
    wr_t        e;

    tick();
    check("rnd err", err, err_exp);
    check("rnd busy", busy, (bus.wr_we != 4'd0) || open);

    if (bus.wr_we != 4'd0) begin
      if (!in_txn) begin
        if (exp_q.size() == 0) begin
          check("rnd unexpected write", bus.wr_we, 4'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd we",   bus.wr_we,   4'b0001 << e.bank);
          check("rnd data", bus.wr_data, e.data);
          check("rnd be",   bus.wr_be,   e.be);
        end
        in_txn = 1'b1;
        t_we = bus.wr_we; t_data = bus.wr_data; t_be = bus.wr_be;
        held = 0;
        ack_delay = $urandom_range(0, 19);
      end else begin
        check("rnd hold", {bus.wr_we, bus.wr_be, bus.wr_data}, {t_we, t_be, t_data});
      end
    end else begin
      if (in_txn) begin
        check("rnd write dropped early", bus.wr_we, t_we);
        in_txn = 1'b0;
      end
      check("rnd idle bus", {bus.wr_be, bus.wr_data}, 36'd0);
    end

    ack = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
    to  = 1'b0;
    if (in_txn) begin
      ack = ack & ~t_we;
      held++;
      if (held - 1 == ack_delay) ack = ack | t_we;
      if ((ack & t_we) != 4'd0) in_txn = 1'b0;
      else if (held == TIMEOUT) begin
        in_txn = 1'b0;
        to = 1'b1;
      end
    end
    clr = ($urandom_range(0, 7) == 0);
    err_exp = (err_exp & ~clr) | to;
    bus.wr_ack = ack;
    err_clr    = clr;

    v    = allow_in && ($urandom_range(0, 2) != 0);
    if (open && $urandom_range(0, 3) != 0) b = ob;
    else b = 2'($urandom_range(0, 3));
    l    = 2'($urandom_range(0, 3));
    d    = 8'($urandom_range(0, 255));
    last = ($urandom_range(0, 5) == 0);
    fl   = force_flush || ($urandom_range(0, 7) == 0);
    ir   = bus.in_ready;
    drive_byte(v, b, l, d, last, fl);
    model_step(ir, v, b, l, d, last, fl);
  endtask

  int n, stale;

  initial begin
    vecs[0] = '{n: 4, bank: 2'd2, lanes: 8'hE4, bytes: 32'h44332211, last: 1'b0,
                exp_data: 32'h44332211, exp_be: 4'hF};
    vecs[1] = '{n: 1, bank: 2'd1, lanes: 8'h01, bytes: 32'h000000AB, last: 1'b1,
                exp_data: 32'h0000AB00, exp_be: 4'b0010};
    vecs[2] = '{n: 3, bank: 2'd0, lanes: 8'h30, bytes: 32'h00770201, last: 1'b0,
                exp_data: 32'h77000002, exp_be: 4'b1001};
    vecs[3] = '{n: 2, bank: 2'd3, lanes: 8'h06, bytes: 32'h00000605, last: 1'b1,
                exp_data: 32'h00050600, exp_be: 4'b0110};

    rst_n = 1'b0;
    err_clr = 1'b0;
    bus.wr_ack = 4'd0;
    idle_in();
    repeat (3) tick();
    check("reset we",    bus.wr_we,    4'd0);
    check("reset data",  bus.wr_data,  32'd0);
    check("reset be",    bus.wr_be,    4'd0);
    check("reset err",   err,          1'b0);
    check("reset busy",  busy,         1'b0);
    check("reset ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;

    // ---- table of single-word writes ----
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        tick();
        drive_byte(1'b1, vecs[v].bank, vecs[v].lanes[2*i +: 2], vecs[v].bytes[8*i +: 8],
                   vecs[v].last && (i == vecs[v].n - 1), 1'b0);
      end
      tick();
      idle_in();
      check("vec we",    bus.wr_we,    4'b0001 << vecs[v].bank);
      check("vec data",  bus.wr_data,  vecs[v].exp_data);
      check("vec be",    bus.wr_be,    vecs[v].exp_be);
      check("vec ready", bus.in_ready, 1'b0);
      tick();
      check("vec held", {bus.wr_we, bus.wr_be, bus.wr_data},
            {4'b0001 << vecs[v].bank, vecs[v].exp_be, vecs[v].exp_data});
      bus.wr_ack = 4'b0001 << vecs[v].bank;
      tick();
      bus.wr_ack = 4'd0;
      check("vec we off", bus.wr_we,    4'd0);
      check("vec ready2", bus.in_ready, 1'b1);
      check("vec busy",   busy,         1'b0);
    end

    // ---- bank switch: byte parked, then written after the first ack ----
    tick(); drive_byte(1'b1, 2'd0, 2'd0, 8'h5A, 1'b0, 1'b0);
    tick(); drive_byte(1'b1, 2'd3, 2'd3, 8'hC3, 1'b0, 1'b0);
    tick(); idle_in();
    check("sw1 we",   bus.wr_we,   4'b0001);
    check("sw1 data", bus.wr_data, 32'h0000005A);
    check("sw1 be",   bus.wr_be,   4'b0001);
    bus.wr_ack = 4'b0001;
    tick();
    bus.wr_ack = 4'b1000;
    check("sw2 we",   bus.wr_we,   4'b1000);
    check("sw2 data", bus.wr_data, 32'hC3000000);
    check("sw2 be",   bus.wr_be,   4'b1000);
    tick();
    bus.wr_ack = 4'd0;
    check("sw done", {busy, bus.wr_we}, 5'd0);

    // ---- timeout: strobe held exactly TIMEOUT cycles ----
    tick(); drive_byte(1'b1, 2'd2, 2'd3, 8'h77, 1'b0, 1'b0);
    tick(); idle_in();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wr_we == 4'b0100) n++;
      else break;
      tick();
    end
    check("to cycles", n, TIMEOUT);
    check("to err", err, 1'b1);
    check("to busy", busy, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to err_clr", err, 1'b0);

    // ---- wrong-bank acks ignored, ack in the last cycle wins ----
    tick(); drive_byte(1'b1, 2'd1, 2'd3, 8'h3C, 1'b0, 1'b0);
    n = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      idle_in();
      if (bus.wr_we == 4'b0010) n++;
      bus.wr_ack = (k == TIMEOUT) ? 4'b0010 : 4'b1101;
    end
    tick();
    bus.wr_ack = 4'd0;
    check("wb held", n, TIMEOUT);
    check("wb we off", bus.wr_we, 4'd0);
    check("wb err", err, 1'b0);

    // ---- timeout with clear in the same cycle, then reset mid-write ----
    tick(); drive_byte(1'b1, 2'd0, 2'd3, 8'h99, 1'b0, 1'b0);
    tick(); idle_in();
    repeat (TIMEOUT - 1) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("setclr err", err, 1'b1);
    drive_byte(1'b1, 2'd2, 2'd3, 8'h11, 1'b0, 1'b0);
    tick(); idle_in();
    check("rst pre we", bus.wr_we, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("rst we",    bus.wr_we,    4'd0);
    check("rst data",  bus.wr_data,  32'd0);
    check("rst err",   err,          1'b0);
    check("rst busy",  busy,         1'b0);
    check("rst ready", bus.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wr_we != 4'd0 || busy) stale++;
    end
    check("rst no stale", stale, 0);
    check("rst ready2", bus.in_ready, 1'b1);

    // ---- randomized phase ----
    open = 1'b0; od = '0; obe = '0; err_exp = 1'b0; in_txn = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1, 1'b0);
    for (int c = 0; c < 80; c++)   rand_cycle(1'b0, 1'b1);
    check("rnd drained", exp_q.size(), 0);
    check("rnd txn closed", in_txn, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
